// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and helpers for the stack-pointer register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and index width.
//   sp_lo_idx(addr_w)               : index of the low half of the stack pointer.
//   sp_hi_idx(addr_w)               : index of the high half of the stack pointer.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;

    // The stack pointer occupies the top two register slots.
    function automatic int sp_lo_idx(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

    function automatic int sp_hi_idx(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_stk_sp_adjust.sv
// sp_adjust
// Combinational stack-pointer adjuster.
//   inc     : post-increment request (pop)
//   dec     : pre-decrement request (push)
//   sp_in   : current SP_W-bit stack pointer
//   sp_next : adjusted stack pointer; inc and dec together cancel out.
// Arithmetic is full-width modulo 2**SP_W, so carries and borrows cross
// between the two register halves naturally.
module sp_adjust
    import regfile_pkg::*;
#(
    parameter int SP_W = 2 * DEFAULT_DATA_W
) (
    input  logic            inc,
    input  logic            dec,
    input  logic [SP_W-1:0] sp_in,
    output logic [SP_W-1:0] sp_next
);

    localparam logic [SP_W-1:0] ONE = {{(SP_W-1){1'b0}}, 1'b1};

    always_comb begin
        sp_next = sp_in;
        case ({inc, dec})
            2'b10:   sp_next = sp_in + ONE;
            2'b01:   sp_next = sp_in - ONE;
            default: sp_next = sp_in;
        endcase
    end

endmodule

// File: rtl/regfile_stk.sv
// regfile_stk
// Register file with a built-in 2*DATA_W-bit stack pointer held in the two
// highest register slots (SP_LO = NREGS-2, SP_HI = NREGS-1).
//   cpu_clk              : clock, all state updates on the rising edge
//   rst                  : synchronous active-high reset
//   src_a_en / src_a     : port A enable / index; a_out floats when disabled
//   src_a_pop            : post-increment SP (only when src_a_en=1)
//   src_b_en / src_b     : port B enable / index; b_out floats when disabled
//   push                 : pre-decrement SP
//   we / src_w / val     : write enable, index, data (index 0 is read-only zero)
//   a_out / b_out        : combinational read data, tri-state
//   sp_out               : registered stack pointer {SP_HI, SP_LO}, never bypassed
module regfile_stk
    import regfile_pkg::*;
#(
    parameter int                    DATA_W   = DEFAULT_DATA_W,
    parameter int                    ADDR_W   = DEFAULT_ADDR_W,
    parameter int                    BYPASS   = 1,
    parameter logic [2*DATA_W-1:0]   SP_RESET = '0
) (
    input  logic                  cpu_clk,
    input  logic                  rst,
    input  logic                  src_a_en,
    input  logic                  src_a_pop,
    input  logic [ADDR_W-1:0]     src_a,
    input  logic                  src_b_en,
    input  logic [ADDR_W-1:0]     src_b,
    input  logic                  push,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     src_w,
    input  logic [DATA_W-1:0]     val,
    output logic [DATA_W-1:0]     a_out,
    output logic [DATA_W-1:0]     b_out,
    output logic [2*DATA_W-1:0]   sp_out
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_LO = ADDR_W'(sp_lo_idx(ADDR_W));
    localparam logic [ADDR_W-1:0] SP_HI = ADDR_W'(sp_hi_idx(ADDR_W));

    logic [DATA_W-1:0]   reg_q [NREGS];
    logic [DATA_W-1:0]   reg_d [NREGS];

    logic                wr_en;
    logic                sp_wr;
    logic                pop_eff;
    logic                sp_inc;
    logic                sp_dec;
    logic [2*DATA_W-1:0] sp_cur;
    logic [2*DATA_W-1:0] sp_next;
    logic [DATA_W-1:0]   a_rd;
    logic [DATA_W-1:0]   b_rd;

    // Control decode. A direct write to either SP half takes priority over
    // any push/pop adjustment in the same cycle.
    assign wr_en   = we && (src_w != '0);
    assign sp_wr   = wr_en && ((src_w == SP_LO) || (src_w == SP_HI));
    assign pop_eff = src_a_pop && src_a_en;
    assign sp_inc  = pop_eff && !sp_wr;
    assign sp_dec  = push && !sp_wr;
    assign sp_cur  = {reg_q[SP_HI], reg_q[SP_LO]};

    sp_adjust #(
        .SP_W (2 * DATA_W)
    ) u_sp_adjust (
        .inc     (sp_inc),
        .dec     (sp_dec),
        .sp_in   (sp_cur),
        .sp_next (sp_next)
    );

    // Next-state of the whole array: SP halves take the adjusted value,
    // then a write (if any) overrides its target slot.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            reg_d[i] = reg_q[i];
        end
        reg_d[SP_LO] = sp_next[DATA_W-1:0];
        reg_d[SP_HI] = sp_next[2*DATA_W-1:DATA_W];
        if (wr_en) begin
            reg_d[src_w] = val;
        end
    end

    // Reset dominates every write and SP adjustment in the same cycle.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
            reg_q[SP_LO] <= SP_RESET[DATA_W-1:0];
            reg_q[SP_HI] <= SP_RESET[2*DATA_W-1:DATA_W];
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
        end
    end

    // Independent read muxes. Index 0 is hard-wired to zero; the write
    // forward only applies to writes that will actually land.
    always_comb begin
        a_rd = reg_q[src_a];
        if (src_a == '0) begin
            a_rd = '0;
        end else if ((BYPASS != 0) && wr_en && (src_a == src_w)) begin
            a_rd = val;
        end
    end

    always_comb begin
        b_rd = reg_q[src_b];
        if (src_b == '0) begin
            b_rd = '0;
        end else if ((BYPASS != 0) && wr_en && (src_b == src_w)) begin
            b_rd = val;
        end
    end

    assign a_out  = src_a_en ? a_rd : {DATA_W{1'bz}};
    assign b_out  = src_b_en ? b_rd : {DATA_W{1'bz}};
    assign sp_out = sp_cur;

endmodule

// File: tb/tb_regfile_stk.sv
// tb_regfile_stk
// Directed bench for regfile_stk: one forwarding instance (SP_RESET=0000_8FFF)
// and one non-forwarding instance driven by the same stimulus.
module tb_regfile_stk;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b0;
    logic        src_a_en = 1'b0;
    logic        src_a_pop = 1'b0;
    logic [3:0]  src_a = '0;
    logic        src_b_en = 1'b0;
    logic [3:0]  src_b = '0;
    logic        push = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  src_w = '0;
    logic [15:0] val = '0;

    wire  [15:0] a_out;
    wire  [15:0] b_out;
    wire  [31:0] sp_out;
    wire  [15:0] nb_a_out;
    wire  [15:0] nb_b_out;
    wire  [31:0] nb_sp_out;

    logic [15:0] z16;

    int n_total = 0;
    int n_bad   = 0;

    always #5 cpu_clk = ~cpu_clk;

    regfile_stk #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .BYPASS   (1),
        .SP_RESET (32'h0000_8FFF)
    ) dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .src_a_en  (src_a_en),
        .src_a_pop (src_a_pop),
        .src_a     (src_a),
        .src_b_en  (src_b_en),
        .src_b     (src_b),
        .push      (push),
        .we        (we),
        .src_w     (src_w),
        .val       (val),
        .a_out     (a_out),
        .b_out     (b_out),
        .sp_out    (sp_out)
    );

    regfile_stk #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .BYPASS   (0),
        .SP_RESET (32'h0000_0000)
    ) dut_nb (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .src_a_en  (src_a_en),
        .src_a_pop (src_a_pop),
        .src_a     (src_a),
        .src_b_en  (src_b_en),
        .src_b     (src_b),
        .push      (push),
        .we        (we),
        .src_w     (src_w),
        .val       (val),
        .a_out     (nb_a_out),
        .b_out     (nb_b_out),
        .sp_out    (nb_sp_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Advance past the next rising edge and leave 1 ns for outputs to settle.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [15:0] data);
        we    = 1'b1;
        src_w = idx;
        val   = data;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        z16 = 'z;

        // Reset while a write and a pop are requested: reset must win.
        rst = 1'b1; we = 1'b1; src_w = 4'd5; val = 16'hBEEF;
        src_a_en = 1'b1; src_a_pop = 1'b1; push = 1'b1;
        tick();
        tick();
        rst = 1'b0; we = 1'b0; src_a_pop = 1'b0; push = 1'b0;
        src_a_en = 1'b1; src_b_en = 1'b1;
        #1;
        chk("rst_sp", sp_out, 64'h0000_8FFF);
        chk("rst_sp_nb", nb_sp_out, 64'h0);

        // Post-reset sweep of all indices on both ports.
        for (int i = 0; i < 16; i++) begin
            src_a = 4'(i);
            src_b = 4'(15 - i);
            #1;
            chk($sformatf("rst_a%0d", i), a_out,
                (i == 14) ? 64'h8FFF : 64'h0);
            chk($sformatf("rst_b%0d", 15 - i), b_out,
                ((15 - i) == 14) ? 64'h8FFF : 64'h0);
        end

        // Write forwarding vs stored-value read.
        we = 1'b1; src_w = 4'd3; val = 16'h1234; src_a = 4'd3; src_b = 4'd3;
        #1;
        chk("byp_a", a_out, 64'h1234);
        chk("byp_b", b_out, 64'h1234);
        chk("nobyp_a", nb_a_out, 64'h0);
        tick();
        we = 1'b0;
        #1;
        chk("wr3_a", a_out, 64'h1234);
        chk("wr3_nb_a", nb_a_out, 64'h1234);

        // Index 0 stays zero, even under a forwarded write.
        we = 1'b1; src_w = 4'd0; val = 16'hFFFF; src_a = 4'd0;
        #1;
        chk("r0_byp", a_out, 64'h0);
        tick();
        we = 1'b0;
        #1;
        chk("r0_after", a_out, 64'h0);

        // we=0 leaves the target untouched.
        we = 1'b0; src_w = 4'd3; val = 16'h5555; src_a = 4'd3;
        tick();
        chk("we0_hold", a_out, 64'h1234);

        // Pop / push around the carry boundary between halves.
        wr(4'd14, 16'hFFFF);
        wr(4'd15, 16'h0000);
        chk("sp_set", sp_out, 64'h0000_FFFF);
        src_a = 4'd14; src_a_en = 1'b1; src_a_pop = 1'b1;
        #1;
        chk("pop_pre", a_out, 64'hFFFF);
        tick();
        src_a_pop = 1'b0;
        chk("pop_carry", sp_out, 64'h0001_0000);
        push = 1'b1;
        tick();
        push = 1'b0;
        chk("push_borrow", sp_out, 64'h0000_FFFF);
        src_a_en = 1'b0; src_a_pop = 1'b1;
        #1;
        chk("pop_dis_z", a_out, {48'h0, z16});
        tick();
        src_a_pop = 1'b0; src_a_en = 1'b1;
        chk("pop_dis_hold", sp_out, 64'h0000_FFFF);

        // Full-width wrap both ways.
        wr(4'd14, 16'h0000);
        wr(4'd15, 16'h0000);
        chk("sp_zero", sp_out, 64'h0);
        push = 1'b1;
        tick();
        chk("push_wrap", sp_out, 64'hFFFF_FFFF);
        src_a_pop = 1'b1;
        tick();
        push = 1'b0;
        chk("push_pop", sp_out, 64'hFFFF_FFFF);
        tick();
        src_a_pop = 1'b0;
        chk("pop_wrap", sp_out, 64'h0);

        // Direct write to an SP half suppresses the adjustment.
        wr(4'd14, 16'h0010);
        wr(4'd15, 16'h0005);
        push = 1'b1; we = 1'b1; src_w = 4'd14; val = 16'h00AA;
        #1;
        chk("sp_nobyp", sp_out, 64'h0005_0010);
        tick();
        push = 1'b0; we = 1'b0;
        chk("push_wr_lo", sp_out, 64'h0005_00AA);
        src_a_pop = 1'b1; we = 1'b1; src_w = 4'd15; val = 16'h1234;
        tick();
        src_a_pop = 1'b0; we = 1'b0;
        chk("pop_wr_hi", sp_out, 64'h1234_00AA);

        // Reset wins over a concurrent write and pop.
        wr(4'd5, 16'hBEEF);
        src_b = 4'd5;
        #1;
        chk("r5_set", b_out, 64'hBEEF);
        rst = 1'b1; we = 1'b1; src_w = 4'd5; val = 16'hBEEF;
        src_a_en = 1'b1; src_a_pop = 1'b1; src_a = 4'd14;
        tick();
        rst = 1'b0; we = 1'b0; src_a_pop = 1'b0; src_a_en = 1'b0;
        #1;
        chk("rst2_r5", b_out, 64'h0);
        chk("rst2_sp", sp_out, 64'h0000_8FFF);
        chk("rst2_a_z", a_out, {48'h0, z16});
        src_b_en = 1'b0;
        #1;
        chk("rst2_b_z", b_out, {48'h0, z16});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_stk.md
REGFILE_STK -- requirements
Module: regfile_stk

Interface
REQ-001 Parameter DATA_W, default 16, register and bus width in bits.
REQ-002 Parameter ADDR_W, default 4, register index width; NREGS = 2**ADDR_W, minimum ADDR_W = 2.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-004 Parameter SP_RESET, default 0, 2*DATA_W-bit reset value of the stack pointer pair.
REQ-005 cpu_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 src_a_en  input  1  drive a_out; when 0, a_out is high-impedance.
REQ-008 src_a_pop  input  1  post-increment the stack pointer; qualified by src_a_en.
REQ-009 src_a  input  ADDR_W  read index for port A.
REQ-010 src_b_en  input  1  drive b_out; when 0, b_out is high-impedance.
REQ-011 src_b  input  ADDR_W  read index for port B.
REQ-012 push  input  1  pre-decrement the stack pointer.
REQ-013 we  input  1  write enable.
REQ-014 src_w  input  ADDR_W  write index.
REQ-015 val  input  DATA_W  write data.
REQ-016 a_out  output  DATA_W  port A read data, tri-state.
REQ-017 b_out  output  DATA_W  port B read data, tri-state.
REQ-018 sp_out  output  2*DATA_W  current stack pointer {reg[NREGS-1], reg[NREGS-2]}, always driven.

Function
REQ-019 Index 0 SHALL read as zero; writes to index 0 SHALL be ignored.
REQ-020 Index NREGS-2 is SP_LO and NREGS-1 is SP_HI; all other indices are general-purpose registers.
REQ-021 A write SHALL occur at the rising edge only when we=1 and src_w!=0; we=0 SHALL leave all general-purpose registers unchanged, whatever the value of src_w.
REQ-022 Reads SHALL be combinational, with zero-cycle latency from the index to the output.
REQ-023 With BYPASS=1, a read whose index equals src_w while we=1 and src_w!=0 SHALL return val in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-024 Pop is effective when src_a_pop=1 and src_a_en=1; a pop with src_a_en=0 SHALL be ignored.
REQ-025 Effective pop alone: at the edge, SP <= SP+1; a_out SHALL show the pre-increment contents during that cycle.
REQ-026 Push alone: at the edge, SP <= SP-1.
REQ-027 Effective pop and push in the same cycle: SP SHALL be unchanged.
REQ-028 SP arithmetic is 2*DATA_W bits with carry/borrow between the halves and modulo wrap: 2**(2*DATA_W)-1 +1 -> 0, and 0 -1 -> all-ones.
REQ-029 When we=1 targets SP_LO or SP_HI in the same cycle as a push or pop, the adjustment SHALL be suppressed for that cycle; the written half takes val and the other half holds.
REQ-030 sp_out SHALL reflect the registered SP only; it SHALL NOT be bypassed.

Reset
REQ-031 While rst=1 at an edge: general-purpose registers <= 0, SP <= SP_RESET; we, push and pop SHALL be ignored.
REQ-032 Reset asserted in the same cycle as a write or SP adjustment SHALL win; no partial update.
REQ-033 After reset: sp_out = SP_RESET; a_out and b_out follow the enables, reading 0 for every index other than SP_LO/SP_HI.

Structure
REQ-034 Package regfile_pkg SHALL hold the default DATA_W and ADDR_W constants and the functions sp_lo_idx(ADDR_W) and sp_hi_idx(ADDR_W).
REQ-035 Sub-module sp_adjust SHALL be combinational: {inc, dec, sp_in} -> sp_next at 2*DATA_W bits; regfile_stk instantiates it once.
REQ-036 Storage SHALL be a single register array; each read port SHALL use its own mux; no latches.

Verification
REQ-037 Reset with SP_RESET=32'h0000_8FFF, then read all 16 indices on A and B with enables=1 -> each reads 0 except idx14=8FFF and idx15=0000.
REQ-038 we=1, src_w=3, val=1234, src_a=3, BYPASS=1 -> a_out=1234 in the same cycle; with BYPASS=0 -> a_out=0 until the next cycle.
REQ-039 SP=0000_FFFF, pop with src_a_en=1 -> SP=0001_0000; push -> SP=0000_FFFF; pop with src_a_en=0 -> SP unchanged.
REQ-040 SP=0, push -> SP=FFFF_FFFF; push and pop together -> SP unchanged.
REQ-041 push=1 with we=1, src_w=14, val=00AA, SP=0005_0010 -> SP=0005_00AA, no decrement.
REQ-042 rst=1 with we=1, src_w=5, val=BEEF and pop=1 -> r5=0, SP=SP_RESET; src_a_en=0 -> a_out=Z.
